// File: rtl/mem_defs_pkg.sv
// Shared definitions for the data-memory stage: aluop codes, FSM states,
// access sizes and the big-endian byte-lane select patterns.
package mem_defs_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_t;

    // Lane 0 is the most significant byte of the bus (big-endian).
    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_H0   = 4'b1100;
    localparam logic [3:0] SEL_H1   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;

    function automatic mem_size_t op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return op_size(op) != SZ_NONE;
    endfunction

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load_op = 1'b1;
            default:                             is_load_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Data-RAM bus between the memory-stage controller (master) and the RAM (slave).
interface mem_ctrl_if;

    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport master (
        output ram_ce,
        output ram_we,
        output ram_addr,
        output ram_sel,
        output ram_wdata,
        input  ram_rdata,
        input  ram_ready
    );

    modport slave (
        input  ram_ce,
        input  ram_we,
        input  ram_addr,
        input  ram_sel,
        input  ram_wdata,
        output ram_rdata,
        output ram_ready
    );

endinterface

// File: rtl/mem_lane.sv
// Big-endian byte-lane logic: RAM lane select, store replication and
// sign/zero extension of the loaded lane.
module mem_lane
    import mem_defs_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    mem_size_t   size;
    logic        sign_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign size     = op_size(aluop);
    assign sign_ext = is_signed_load(aluop);

    // Only the address bits inside the access size pick a lane; the rest are ignored.
    always_comb begin
        sel       = SEL_NONE;
        wdata     = '0;
        load_data = '0;
        byte_lane = '0;
        half_lane = '0;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00: begin sel = SEL_B0; byte_lane = rdata[31:24]; end
                    2'b01: begin sel = SEL_B1; byte_lane = rdata[23:16]; end
                    2'b10: begin sel = SEL_B2; byte_lane = rdata[15:8];  end
                    default: begin sel = SEL_B3; byte_lane = rdata[7:0]; end
                endcase
                wdata     = {4{store_data[7:0]}};
                load_data = sign_ext ? {{24{byte_lane[7]}}, byte_lane}
                                     : {24'b0, byte_lane};
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    sel       = SEL_H1;
                    half_lane = rdata[15:0];
                end else begin
                    sel       = SEL_H0;
                    half_lane = rdata[31:16];
                end
                wdata     = {2{store_data[15:0]}};
                load_data = sign_ext ? {{16{half_lane[15]}}, half_lane}
                                     : {16'b0, half_lane};
            end
            SZ_WORD: begin
                sel       = SEL_W;
                wdata     = store_data;
                load_data = rdata;
            end
            default: begin
                sel = SEL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-stage controller: passes non-memory results to write-back and runs
// loads/stores on the data RAM. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_ctrl
    import mem_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,

    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        excpt_align,
    output logic [31:0] excpt_addr,

    mem_ctrl_if.master  ram
);

    mem_state_t  state;
    logic        mem_op;
    logic        load_op;
    logic        misaligned;
    logic        issue;
    logic        access;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign mem_op  = is_mem_op(mem_aluop);
    assign load_op = is_load_op(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (op_size(mem_aluop))
            SZ_HALF: misaligned = mem_mem_addr[0];
            SZ_WORD: misaligned = |mem_mem_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign issue  = mem_op && !misaligned;
    assign access = (state == ACCESS) && !rst;

    assign stallreq = ((state == IDLE) && issue) ||
                      ((state == ACCESS) && !ram.ram_ready);

    mem_lane lane (
        .aluop      (mem_aluop),
        .addr_lo    (mem_mem_addr[1:0]),
        .store_data (mem_reg2),
        .rdata      (ram.ram_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // The RAM request is decoded straight from the state so a reset drops it at once.
    assign ram.ram_ce    = access;
    assign ram.ram_we    = access && !load_op;
    assign ram.ram_addr  = access ? {mem_mem_addr[31:2], 2'b00} : '0;
    assign ram.ram_sel   = access ? lane_sel : SEL_NONE;
    assign ram.ram_wdata = (access && !load_op) ? lane_wdata : '0;

    // Every stalled cycle writes a bubble; wb_wd/wb_wdata keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state   <= ACCESS;
                        wb_wreg <= 1'b0;
                    end else if (mem_op) begin
                        wb_wreg <= 1'b0;
                    end else begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg;
                        wb_wdata <= mem_wdata;
                    end
                end
                ACCESS: begin
                    if (ram.ram_ready) begin
                        state <= IDLE;
                        if (load_op) begin
                            wb_wd    <= mem_wd;
                            wb_wreg  <= mem_wreg;
                            wb_wdata <= lane_load;
                        end else begin
                            wb_wreg <= 1'b0;
                        end
                    end else begin
                        wb_wreg <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    wb_wreg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // A misaligned op never leaves IDLE; it raises a one-cycle trap and keeps the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excpt_align <= 1'b0;
            excpt_addr  <= '0;
        end else begin
            excpt_align <= (state == IDLE) && mem_op && misaligned;
            if ((state == IDLE) && mem_op && misaligned) begin
                excpt_addr <= mem_mem_addr;
            end
        end
    end
`else
    assign excpt_align = 1'b0;
    assign excpt_addr  = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a directed vector table, hand-written reset and alignment
// sequences, and randomized transactions checked against a byte-level model.
module tb_mem_ctrl;
    import mem_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        excpt_align;
    logic [31:0] excpt_addr;

    mem_ctrl_if ram_bus ();

    mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .stallreq     (stallreq),
        .excpt_align  (excpt_align),
        .excpt_addr   (excpt_addr),
        .ram          (ram_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0]  exp_wd;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
    logic        exp_align;
    logic [31:0] exp_addr;

    logic [7:0] mem_codes [8] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          delay;
        logic        idle_ready;
        logic [3:0]  sel;
        logic [31:0] store_word;
        logic [31:0] result;
    } txn_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  sel;
        logic [31:0] store_word;
        logic [31:0] result;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_wb(input string tag);
        check_output({tag, ".wb_wd"},       32'(wb_wd),       32'(exp_wd));
        check_output({tag, ".wb_wreg"},     32'(wb_wreg),     32'(exp_wreg));
        check_output({tag, ".wb_wdata"},    wb_wdata,         exp_wdata);
        check_output({tag, ".excpt_align"}, 32'(excpt_align), 32'(exp_align));
        check_output({tag, ".excpt_addr"},  excpt_addr,       exp_addr);
    endtask

    // Reference model: access size in bytes, 0 for anything that is not a memory op.
    function automatic int model_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic logic model_is_load(input logic [7:0] op);
        return (model_size(op) != 0) && (op < 8'hE8);
    endfunction

    function automatic logic model_misaligned(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        return (model_size(op) == 2 && addr[0]) || (model_size(op) == 4 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        case (model_size(op))
            1:       return 4'b1000 >> addr[1:0];
            2:       return addr[1] ? 4'b0011 : 4'b1100;
            4:       return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] reg2);
        case (model_size(op))
            1:       return 32'(reg2[7:0]) * 32'h01010101;
            2:       return 32'(reg2[15:0]) * 32'h00010001;
            default: return reg2;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        int          sz;
        int          idx;
        logic [31:0] mask;
        logic [31:0] v;
        sz   = model_size(op);
        idx  = (sz == 1) ? int'(addr[1:0]) : ((sz == 2 && addr[1]) ? 2 : 0);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (sz * 8)) - 32'h1);
        v    = (rdata >> ((4 - sz - idx) * 8)) & mask;
        if ((op == 8'hE0 || op == 8'hE1) && v[sz * 8 - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic txn_t model_txn(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                                       input logic [31:0] wdata, input logic [31:0] addr,
                                       input logic [31:0] reg2, input logic [31:0] rdata,
                                       input int delay, input logic idle_ready);
        txn_t t;
        t.op = op; t.wd = wd; t.wreg = wreg; t.wdata = wdata; t.addr = addr;
        t.reg2 = reg2; t.rdata = rdata; t.delay = delay; t.idle_ready = idle_ready;
        t.sel        = model_sel(op, addr);
        t.store_word = model_store(op, reg2);
        t.result     = model_load(op, addr, rdata);
        return t;
    endfunction

    // Drives one pipeline op; memory ops are served by the bench after t.delay not-ready cycles.
    task automatic apply_stimulus(input txn_t t);
        int   stall_cycles;
        logic load;
        logic ready;
        stall_cycles = 0;
        load = model_is_load(t.op);
        mem_aluop = t.op; mem_wd = t.wd; mem_wreg = t.wreg; mem_wdata = t.wdata;
        mem_mem_addr = t.addr; mem_reg2 = t.reg2;
        ram_bus.ram_ready = t.idle_ready;
        ram_bus.ram_rdata = $urandom;
        @(negedge clk);
        check_output("idle.ram_ce", 32'(ram_bus.ram_ce), 32'd0);
        if (model_size(t.op) == 0 || model_misaligned(t.op, t.addr)) begin
            check_output("idle.stallreq_low", 32'(stallreq), 32'd0);
            @(posedge clk); #1;
            if (model_size(t.op) == 0) begin
                exp_wd = t.wd; exp_wreg = t.wreg; exp_wdata = t.wdata; exp_align = 1'b0;
            end else begin
                exp_wreg = 1'b0; exp_align = 1'b1; exp_addr = t.addr;
            end
            check_wb(model_size(t.op) == 0 ? "pass" : "fault");
        end else begin
            check_output("idle.stallreq_high", 32'(stallreq), 32'd1);
            if (stallreq) stall_cycles++;
            @(posedge clk); #1;
            exp_wreg = 1'b0; exp_align = 1'b0;
            check_wb("issue");
            for (int c = 0; c <= t.delay; c++) begin
                ready = (c == t.delay);
                ram_bus.ram_ready = ready;
                ram_bus.ram_rdata = ready ? t.rdata : $urandom;
                @(negedge clk);
                check_output("acc.ram_ce",   32'(ram_bus.ram_ce),   32'd1);
                check_output("acc.ram_we",   32'(ram_bus.ram_we),   32'(!load));
                check_output("acc.ram_addr", ram_bus.ram_addr,      t.addr & 32'hFFFF_FFFC);
                check_output("acc.ram_sel",  32'(ram_bus.ram_sel),  32'(t.sel));
                if (!load) check_output("acc.ram_wdata", ram_bus.ram_wdata, t.store_word);
                check_output("acc.stallreq", 32'(stallreq), 32'(!ready));
                if (stallreq) stall_cycles++;
                @(posedge clk); #1;
                if (ready && load) begin
                    exp_wd = t.wd; exp_wreg = t.wreg; exp_wdata = t.result;
                end else begin
                    exp_wreg = 1'b0;
                end
                check_wb(ready ? "done" : "wait");
            end
            check_output("stall_cycles", 32'(stall_cycles), 32'(t.delay + 1));
        end
        ram_bus.ram_ready = 1'b0;
    endtask

    vec_t vectors [9];

    initial begin
        vectors[0] = '{8'hE0, 32'h0000_0101, 32'h0,         32'h00F0_0000, 0, 4'b0100, 32'h0,         32'hFFFF_FFF0};
        vectors[1] = '{8'hE9, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         3, 4'b0011, 32'hABCD_ABCD, 32'h0};
        vectors[2] = '{8'hE5, 32'h0000_0000, 32'h0,         32'h8001_FFFF, 0, 4'b1100, 32'h0,         32'h0000_8001};
        vectors[3] = '{8'hE1, 32'h0000_0002, 32'h0,         32'h1234_8765, 1, 4'b0011, 32'h0,         32'hFFFF_8765};
        vectors[4] = '{8'hE4, 32'h0000_0003, 32'h0,         32'h0000_00AB, 1, 4'b0001, 32'h0,         32'h0000_00AB};
        vectors[5] = '{8'hE3, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vectors[6] = '{8'hE8, 32'h0000_0020, 32'h1234_567A, 32'h0,         0, 4'b1000, 32'h7A7A_7A7A, 32'h0};
        vectors[7] = '{8'hEB, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,         2, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vectors[8] = '{8'hE0, 32'h0000_0007, 32'h0,         32'h0000_007F, 0, 4'b0001, 32'h0,         32'h0000_007F};

        rst = 1'b1;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_aluop = 8'h00;
        mem_mem_addr = '0; mem_reg2 = '0;
        ram_bus.ram_ready = 1'b0; ram_bus.ram_rdata = '0;
        exp_wd = '0; exp_wreg = 1'b0; exp_wdata = '0; exp_align = 1'b0; exp_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check_wb("reset");
        check_output("reset.ram_ce",   32'(ram_bus.ram_ce), 32'd0);
        check_output("reset.stallreq", 32'(stallreq),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        begin
            txn_t t;
            t = model_txn(8'h00, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0, 1'b0);
            apply_stimulus(t);
        end

        for (int i = 0; i < 9; i++) begin
            txn_t t;
            t.op = vectors[i].op; t.wd = 5'(i + 1); t.wreg = 1'b1; t.wdata = $urandom;
            t.addr = vectors[i].addr; t.reg2 = vectors[i].reg2; t.rdata = vectors[i].rdata;
            t.delay = vectors[i].delay; t.idle_ready = (i % 2 == 1);
            t.sel = vectors[i].sel; t.store_word = vectors[i].store_word; t.result = vectors[i].result;
            apply_stimulus(t);
        end

        // Reset in the middle of a word load: request drops at once, nothing is written back.
        mem_aluop = 8'hE3; mem_mem_addr = 32'h0000_0040; mem_wd = 5'd9; mem_wreg = 1'b1;
        ram_bus.ram_ready = 1'b0;
        @(posedge clk); #1;
        check_output("rst_mid.ce_before", 32'(ram_bus.ram_ce), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_wd = '0; exp_wreg = 1'b0; exp_wdata = '0; exp_align = 1'b0; exp_addr = '0;
        check_output("rst_mid.ram_ce", 32'(ram_bus.ram_ce), 32'd0);
        check_output("rst_mid.state_idle", 32'(dut.state == IDLE), 32'd1);
        check_wb("rst_mid");
        mem_aluop = 8'h00; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h0000_0055;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_wd = 5'd3; exp_wreg = 1'b1; exp_wdata = 32'h0000_0055;
        check_wb("after_rst");

        begin
            txn_t t;
            t = model_txn(8'hE3, 5'd7, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
            $display("[TB] misaligned LW expected to trap");
`else
            $display("[TB] misaligned LW expected to run as an aligned word access");
`endif
            apply_stimulus(t);
            t = model_txn(8'h00, 5'd8, 1'b1, 32'h0000_0088, 32'h0, 32'h0, 32'h0, 0, 1'b0);
            apply_stimulus(t);
        end

        for (int n = 0; n < 300; n++) begin
            txn_t t;
            logic [7:0] op;
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 8) op = mem_codes[pick];
            else if (pick == 8) op = 8'($urandom_range(8'hE0, 8'hEF));
            else op = 8'($urandom);
            t = model_txn(op, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), 1'($urandom));
            apply_stimulus(t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
